// File: rtl/rpn_exec.sv
// rpn_exec: RPN command sequencer for a stack; in: clk, rst, cmd_valid/op/imm, stk_data_out/count; out: cmd_ready, stk_push/pop/data_in, done, err
module rpn_exec #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic [DEPTH-1:0] stk_count,
  output logic             done,
  output logic             err
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_DROP = 3'd2, OP_DUP = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4, OP_ADD = 3'd5, OP_SUB = 3'd6, OP_AND = 3'd7;
  typedef enum logic [2:0] {IDLE, POP_A, POP_B, PUSH1, PUSH2, DONE} state_t;
  state_t r_state, w_next;
  logic [2:0] r_op;
  logic [WIDTH-1:0] r_imm, r_a, r_b, w_res;
  logic r_err, w_acc, w_bad;
  always_comb begin
    cmd_ready = (r_state == IDLE) && !rst;
    w_acc = cmd_valid && cmd_ready;
    w_bad = ((cmd_op == OP_DROP || cmd_op == OP_DUP) && stk_count == '0) ||
            (cmd_op >= OP_SWAP && stk_count < DEPTH'(2)) ||
            ((cmd_op == OP_PUSH || cmd_op == OP_DUP) && (&stk_count));
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_acc ? IDLE : (w_bad || cmd_op == OP_NOP) ? DONE :
                        (cmd_op == OP_PUSH || cmd_op == OP_DUP) ? PUSH1 : POP_A;
      POP_A:   w_next = (r_op == OP_DROP) ? DONE : POP_B;
      POP_B:   w_next = PUSH1;
      PUSH1:   w_next = (r_op == OP_SWAP) ? PUSH2 : DONE;
      PUSH2:   w_next = DONE;
      default: w_next = IDLE;
    endcase
    // PUSH1 carries the literal, the duplicated/swapped top, or the ALU result
    w_res = r_op == OP_ADD  ? r_b + r_a :
            r_op == OP_SUB  ? r_b - r_a :
            r_op == OP_AND  ? r_b & r_a :
            r_op == OP_PUSH ? r_imm : r_a;
    stk_push = (r_state == PUSH1) || (r_state == PUSH2);
    stk_pop = (r_state == POP_A) || (r_state == POP_B);
    stk_data_in = r_state == PUSH1 ? w_res : r_state == PUSH2 ? r_b : '0;
    done = r_state == DONE;
    err = (r_state == DONE) && r_err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op <= OP_NOP;
      r_imm <= '0;
      r_a <= '0;
      r_b <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_op <= cmd_op;
        r_imm <= cmd_imm;
        r_a <= stk_data_out;
        r_err <= w_bad;
      end
      if (r_state == POP_B) r_b <= stk_data_out;
    end
  end
endmodule
